apb_slave_demux: RTL
====================

Name: apb_slave_demux

Overview:
- Downstream neighbour of the AXI-to-APB bridge.
- Takes its single APB master stream and routes each transfer to one of NUM_SLAVES APB completers, selected by address region.
- Registers each transfer before forwarding it and runs a per-transfer PREADY timeout.
- Unmapped addresses and hung completers get a PSLVERR response, so the upstream bridge never stalls forever.

Parameters:
- NUM_SLAVES, 4, number of downstream completers (>=2).
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, APB data width.
- REGION_LSB, 12, log2 of per-slave region size in bytes.
- BASE_ADDR, 32'h0, base of the decoded window; bits below REGION_LSB+IDXW are ignored (IDXW = $clog2(NUM_SLAVES)).
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles before abort; 0 disables the timeout.

Ports:
- aclk, in, 1, clock.
- areset, in, 1, reset; synchronous to aclk, active-high.
- PSEL, in, 1, upstream select.
- PADDR, in, ADDR_WIDTH, upstream address.
- PENABLE, in, 1, upstream enable.
- PWRITE, in, 1, upstream direction.
- PWDATA, in, DATA_WIDTH, upstream write data.
- PRDATA, out, DATA_WIDTH, upstream read data.
- PREADY, out, 1, upstream ready.
- PSLVERR, out, 1, upstream error.
- m_psel, out, NUM_SLAVES, one-hot downstream select.
- m_paddr, out, ADDR_WIDTH, downstream address (shared by all completers).
- m_penable, out, 1, downstream enable.
- m_pwrite, out, 1, downstream direction.
- m_pwdata, out, DATA_WIDTH, downstream write data.
- m_prdata, in, NUM_SLAVES*DATA_WIDTH, per-slave read data; slave i occupies [i*DW +: DW].
- m_pready, in, NUM_SLAVES, per-slave ready.
- m_pslverr, in, NUM_SLAVES, per-slave error.
- timeout_evt, out, 1, one-cycle pulse when a transfer is aborted by timeout.

Behaviour:
- Single clock domain; all state is updated on the rising edge of aclk.
- Reset (areset=1, synchronous): state=IDLE, counter=0, captured registers=0.
  - Outputs after reset: PREADY=0, PSLVERR=0, PRDATA=0, m_psel=0, m_penable=0, m_pwrite=0, m_paddr=0, m_pwdata=0, timeout_evt=0.
  - Reset mid-transfer drops the transfer immediately; no response is issued.
- Decode:
  - idx = PADDR[REGION_LSB +: IDXW].
  - Hit requires PADDR[ADDR_WIDTH-1:REGION_LSB+IDXW] == BASE_ADDR[ADDR_WIDTH-1:REGION_LSB+IDXW] and idx < NUM_SLAVES.
  - Otherwise the transfer is unmapped.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - On PSEL=1 and PENABLE=0, capture PADDR, PWRITE, PWDATA, idx and hit.
  - hit -> SETUP; miss -> RESP with error=1 and rdata=0.
  - All downstream outputs are 0 in IDLE.
- SETUP:
  - m_psel[idx]=1, m_penable=0; m_paddr/m_pwrite/m_pwdata driven from the captured registers.
  - Always -> ACCESS after one cycle.
- ACCESS:
  - m_psel[idx]=1, m_penable=1; counter increments each cycle.
  - On m_pready[idx]=1: capture m_prdata slice idx (reads only, else 0) and m_pslverr[idx] -> RESP.
  - Else, if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: capture error=1, rdata=0, pulse timeout_evt for that cycle -> RESP. The downstream transfer is abandoned (m_psel drops next cycle).
  - m_pready[idx] and timeout in the same cycle: ready wins, no timeout_evt.
  - m_pready/m_pslverr of non-selected slaves are ignored.
- RESP:
  - PREADY=1, PSLVERR=captured error, PRDATA=captured rdata, all for exactly one cycle; m_psel=0, m_penable=0.
  - Always -> IDLE; counter cleared.
- Upstream PREADY is 0 in every state except RESP; PRDATA=0 outside RESP.
- Latency: upstream setup in cycle T (T = setup cycle).
  - Zero-wait mapped slave: PREADY at T+3.
  - Each downstream wait state adds one cycle.
  - Unmapped: PREADY at T+1.
- Upstream PSEL/PENABLE changes while not in IDLE are ignored; the captured transfer always runs to completion.
- A new transfer is accepted only in IDLE; back-to-back transfers therefore have one idle cycle between RESP and the next SETUP.

Test Plan:
- Write, PADDR=0x0000_2004, PWDATA=0xA5A5_0001, slave 2 zero-wait -> m_psel=4'b0100 at T+1, m_penable at T+2, m_pwdata=0xA5A5_0001, PREADY=1 and PSLVERR=0 at T+3.
- Read from slave 1 with 3 wait states, m_prdata slice 1 = 0xDEAD_BEEF -> PREADY at T+6 with PRDATA=0xDEAD_BEEF; slave 1 m_pslverr=1 -> PSLVERR=1.
- Unmapped address 0x0001_0000 with BASE_ADDR=0 -> m_psel stays 0, PREADY=1 and PSLVERR=1 at T+1, PRDATA=0.
- TIMEOUT_CYCLES=8, slave 3 never ready -> timeout_evt pulses in the 8th ACCESS cycle; next cycle PREADY=1, PSLVERR=1, m_psel=0. Repeat with m_pready asserted in that 8th cycle -> no timeout_evt, PSLVERR=0.
- areset asserted during ACCESS of a read -> next cycle all outputs 0 and state IDLE. A following transfer to slave 0 completes normally at T+3.
- Back-to-back reads to slaves 0 then 3 -> second SETUP one cycle after the first RESP. m_pready/m_pslverr toggling on unselected slaves does not affect the responses.

Source files
------------

// File: rtl/apb_slave_demux.sv
// APB one-to-many demultiplexer with registered forwarding.
// Unmapped or hung transfers complete upstream with PSLVERR.
module apb_slave_demux #(
    parameter int                    NUM_SLAVES     = 4,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    REGION_LSB     = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                    TIMEOUT_CYCLES = 256
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic                             PSEL,
    input  logic [ADDR_WIDTH-1:0]            PADDR,
    input  logic                             PENABLE,
    input  logic                             PWRITE,
    input  logic [DATA_WIDTH-1:0]            PWDATA,
    output logic [DATA_WIDTH-1:0]            PRDATA,
    output logic                             PREADY,
    output logic                             PSLVERR,
    output logic [NUM_SLAVES-1:0]            m_psel,
    output logic [ADDR_WIDTH-1:0]            m_paddr,
    output logic                             m_penable,
    output logic                             m_pwrite,
    output logic [DATA_WIDTH-1:0]            m_pwdata,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] m_prdata,
    input  logic [NUM_SLAVES-1:0]            m_pready,
    input  logic [NUM_SLAVES-1:0]            m_pslverr,
    output logic                             timeout_evt
);

    localparam int IDXW = $clog2(NUM_SLAVES);
    localparam int HI   = REGION_LSB + IDXW;
    localparam int CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDXW:0] NS   = NUM_SLAVES[IDXW:0];
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                state, state_n;
    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [IDXW-1:0]       idx_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [IDXW-1:0]       idx;
    logic                  hit;
    logic                  ack;
    logic                  tmo;
    logic [DATA_WIDTH-1:0] sel_rdata;

    // Region decode of the incoming address and selected-slave response taps
    always_comb begin
        idx = PADDR[REGION_LSB +: IDXW];
        hit = (PADDR[ADDR_WIDTH-1:HI] == BASE_ADDR[ADDR_WIDTH-1:HI])
              && ({1'b0, idx} < NS);
        ack = m_pready[idx_q];
        sel_rdata = m_prdata[int'(idx_q) * DATA_WIDTH +: DATA_WIDTH];
        tmo = (TIMEOUT_CYCLES != 0) && !ack && (cnt == TMAX);
    end

    // State register plus captured transfer and response
    always_ff @(posedge aclk) begin
        if (areset) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (PSEL && !PENABLE) begin
                        addr_q  <= PADDR;
                        wr_q    <= PWRITE;
                        wdata_q <= PWDATA;
                        idx_q   <= idx;
                        err_q   <= !hit;
                        rdata_q <= '0;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (ack) begin
                        rdata_q <= wr_q ? '0 : sel_rdata;
                        err_q   <= m_pslverr[idx_q];
                    end else if (tmo) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                RESP:    cnt <= '0;
                default: ;
            endcase
        end
    end

    // Next-state and output decode
    always_comb begin
        state_n     = state;
        PRDATA      = '0;
        PREADY      = 1'b0;
        PSLVERR     = 1'b0;
        m_psel      = '0;
        m_paddr     = '0;
        m_penable   = 1'b0;
        m_pwrite    = 1'b0;
        m_pwdata    = '0;
        timeout_evt = 1'b0;
        case (state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_n = hit ? SETUP : RESP;
                end
            end
            SETUP: begin
                m_psel[idx_q] = 1'b1;
                m_paddr       = addr_q;
                m_pwrite      = wr_q;
                m_pwdata      = wdata_q;
                state_n       = ACCESS;
            end
            ACCESS: begin
                m_psel[idx_q] = 1'b1;
                m_penable     = 1'b1;
                m_paddr       = addr_q;
                m_pwrite      = wr_q;
                m_pwdata      = wdata_q;
                timeout_evt   = tmo;
                if (ack || tmo) begin
                    state_n = RESP;
                end
            end
            RESP: begin
                PREADY  = 1'b1;
                PSLVERR = err_q;
                PRDATA  = rdata_q;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
